// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes,
// waits on the memory ready handshake and counts retired instructions.
module control_fsm #(
  parameter int unsigned OP_WIDTH  = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_WIDTH-1:0]  opCode,
  input  logic                 zero,
  input  logic                 memReady,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic [1:0]           pcSrc,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 regWrite,
  output logic                 extendCheck,
  output logic                 regWSource,
  output logic [1:0]           aluOp,
  output logic                 halted,
  output logic                 illegalOp,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [OP_WIDTH-1:0] OpAdd  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OpSub  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OpAnd  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OpOr   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OpAddi = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OpLw   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OpSw   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OpBeq  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OpJ    = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OpHalt = OP_WIDTH'(15);

  state_e               state_q, state_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 illegal_q, illegal_d;
  logic                 retire;

  // opReg is only loaded at the end of DECODE, so DECODE itself decodes the live opcode.
  logic [OP_WIDTH-1:0]  cur_op;
  logic                 is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, is_illegal;

  always_comb begin
    cur_op     = (state_q == StDecode) ? opCode : op_q;
    is_rtype   = (cur_op == OpAdd) || (cur_op == OpSub) || (cur_op == OpAnd) || (cur_op == OpOr);
    is_addi    = (cur_op == OpAddi);
    is_lw      = (cur_op == OpLw);
    is_sw      = (cur_op == OpSw);
    is_beq     = (cur_op == OpBeq);
    is_j       = (cur_op == OpJ);
    is_halt    = (cur_op == OpHalt);
    is_illegal = !(is_rtype || is_addi || is_lw || is_sw || is_beq || is_j || is_halt);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    illegal_d   = illegal_q;
    retire      = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcSrc       = 2'b00;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    regWrite    = 1'b0;
    extendCheck = 1'b0;
    regWSource  = 1'b0;
    aluOp       = 2'b00;
    halted      = 1'b0;

    unique case (state_q)
      StFetch: begin
        memRead = 1'b1;
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady) state_d = StDecode;
      end
      StDecode: begin
        op_d = opCode;
        if (is_halt) begin
          state_d = StHalt;
        end else if (is_illegal) begin
          state_d   = StFetch;
          illegal_d = 1'b1;
        end else if (is_j) begin
          pcWrite = 1'b1;
          pcSrc   = 2'b10;
          state_d = StFetch;
          retire  = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        extendCheck = is_addi || is_lw || is_sw;
        if (cur_op == OpSub || is_beq) begin
          aluOp = 2'b01;
        end else if (cur_op == OpAnd) begin
          aluOp = 2'b10;
        end else if (cur_op == OpOr) begin
          aluOp = 2'b11;
        end
        if (is_beq) begin
          pcWrite = zero;
          pcSrc   = 2'b01;
          state_d = StFetch;
          retire  = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        extendCheck = 1'b1;
        memRead     = is_lw;
        memWrite    = is_sw;
        if (memReady) begin
          if (is_sw) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        regWrite   = 1'b1;
        regWSource = is_lw;
        state_d    = StFetch;
        retire     = 1'b1;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    retired_d = (retire && !(&retired_q)) ? retired_q + 1'b1 : retired_q;

    // No access may be requested while reset is held.
    if (reset) begin
      irWrite     = 1'b0;
      pcWrite     = 1'b0;
      pcSrc       = 2'b00;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      regWrite    = 1'b0;
      extendCheck = 1'b0;
      regWSource  = 1'b0;
      aluOp       = 2'b00;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      op_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign state     = state_q;
  assign retired   = retired_q;
  assign illegalOp = illegal_q;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: a per-instruction trace model builds the expected
// cycle-by-cycle outputs from the opcode rules and latencies, then replays it against the DUT.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opCode;
  logic       zero;
  logic       memReady;
  logic       irWrite, pcWrite, memRead, memWrite, regWrite, extendCheck, regWSource;
  logic       halted, illegalOp;
  logic [1:0] pcSrc, aluOp;
  logic [2:0] state;
  logic [7:0] retired;

  control_fsm #(.OP_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .zero(zero), .memReady(memReady),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .memRead(memRead),
    .memWrite(memWrite), .regWrite(regWrite), .extendCheck(extendCheck),
    .regWSource(regWSource), .aluOp(aluOp), .halted(halted), .illegalOp(illegalOp),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [11:0] ctl;
    logic [3:0]  op;
    logic        mr;
    logic        zr;
    logic [7:0]  ret;
    logic        ill;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   exp_ret = 0;
  logic exp_ill = 1'b0;

  logic [11:0] ctl_act;
  assign ctl_act = {irWrite, pcWrite, pcSrc, memRead, memWrite, regWrite, extendCheck,
                    regWSource, aluOp, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic ir, input logic pc, input logic [1:0] ps,
                                     input logic mrd, input logic mwr, input logic rw,
                                     input logic ex, input logic rs, input logic [1:0] al,
                                     input logic hl);
    return {ir, pc, ps, mrd, mwr, rw, ex, rs, al, hl};
  endfunction

  function automatic void push(input logic [2:0] st, input logic [11:0] ctl,
                               input logic [3:0] op, input logic mr, input logic zr);
    rec_t r;
    r.st  = st;  r.ctl = ctl; r.op = op; r.mr = mr; r.zr = zr;
    r.ret = 8'(exp_ret);
    r.ill = exp_ill;
    q.push_back(r);
  endfunction

  function automatic void retire_one();
    exp_ret = (exp_ret >= 255) ? 255 : exp_ret + 1;
  endfunction

  // Expected trace of one instruction: fs FETCH stalls, ms MEM stalls.
  function automatic void build(input logic [3:0] op, input logic zr, input int fs,
                                input int ms);
    logic [1:0] al;
    logic       ex;
    al = (op == 4'd1 || op == 4'd7) ? 2'd1 : (op == 4'd2) ? 2'd2 : (op == 4'd3) ? 2'd3 : 2'd0;
    ex = (op >= 4'd4 && op <= 4'd6);
    for (int i = 0; i < fs; i++)
      push(3'd0, mk(0, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0, 0), 4'($urandom), 1'b0, 1'($urandom));
    push(3'd0, mk(1, 1, 2'd0, 1, 0, 0, 0, 0, 2'd0, 0), 4'($urandom), 1'b1, 1'($urandom));
    if (op == 4'd15) begin
      push(3'd1, 12'd0, op, 1'($urandom), 1'($urandom));
      return;
    end
    if (op >= 4'd9 && op <= 4'd14) begin
      push(3'd1, 12'd0, op, 1'($urandom), 1'($urandom));
      exp_ill = 1'b1;
      return;
    end
    if (op == 4'd8) begin
      push(3'd1, mk(0, 1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 0), op, 1'($urandom), 1'($urandom));
      retire_one();
      return;
    end
    push(3'd1, 12'd0, op, 1'($urandom), 1'($urandom));
    if (op == 4'd7) begin
      push(3'd2, mk(0, zr, 2'd1, 0, 0, 0, 0, 0, al, 0), op, 1'($urandom), zr);
      retire_one();
      return;
    end
    push(3'd2, mk(0, 0, 2'd0, 0, 0, 0, ex, 0, al, 0), op, 1'($urandom), 1'($urandom));
    if (op == 4'd5 || op == 4'd6) begin
      for (int i = 0; i < ms; i++)
        push(3'd3, mk(0, 0, 2'd0, op == 4'd5, op == 4'd6, 0, 1, 0, 2'd0, 0), op, 1'b0,
             1'($urandom));
      push(3'd3, mk(0, 0, 2'd0, op == 4'd5, op == 4'd6, 0, 1, 0, 2'd0, 0), op, 1'b1,
           1'($urandom));
      if (op == 4'd6) begin
        retire_one();
        return;
      end
    end
    push(3'd4, mk(0, 0, 2'd0, 0, 0, 1, 0, op == 4'd5, 2'd0, 0), op, 1'($urandom),
         1'($urandom));
    retire_one();
  endfunction

  task automatic run_q(input int n);
    rec_t r;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      r = q.pop_front();
      opCode   = r.op;
      zero     = r.zr;
      memReady = r.mr;
      @(negedge clk);
      chk("state", 32'(state), 32'(r.st));
      chk("strobes", 32'(ctl_act), 32'(r.ctl));
      chk("retired", 32'(retired), 32'(r.ret));
      chk("illegalOp", 32'(illegalOp), 32'(r.ill));
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    q.delete();
    reset    = 1'b1;
    memReady = 1'($urandom);
    @(negedge clk);
    chk("rst_strobes", 32'(ctl_act), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    memReady = 1'b0;
    exp_ret  = 0;
    exp_ill  = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_illegal", 32'(illegalOp), 32'd0);
    chk("rst_memWrite", 32'(memWrite), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1; opCode = '0; zero = 1'b0; memReady = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    build(4'd0, 1'b0, 0, 0);
    run_q(1000);
    chk("add_retired", 32'(retired), 32'd1);

    build(4'd5, 1'b0, 0, 3);
    run_q(1000);
    build(4'd7, 1'b1, 0, 0);
    build(4'd7, 1'b0, 0, 0);
    run_q(1000);
    chk("beq_retired", 32'(retired), 32'd4);

    build(4'd10, 1'b0, 0, 0);
    build(4'd8, 1'b0, 0, 0);
    run_q(1000);
    chk("illegal_sticky", 32'(illegalOp), 32'd1);

    do_reset();
    for (int k = 0; k < 150; k++) begin
      build(4'($urandom_range(0, 14)), 1'($urandom), $urandom_range(0, 2),
            $urandom_range(0, 2));
      run_q(1000);
    end

    do_reset();
    for (int k = 0; k < 300; k++) begin
      build(4'd0, 1'b0, 0, 0);
      run_q(1000);
    end
    chk("saturate", 32'(retired), 32'd255);

    build(4'd15, 1'b0, 1, 0);
    for (int k = 0; k < 3; k++)
      push(3'd5, mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1), 4'($urandom), 1'($urandom),
           1'($urandom));
    run_q(1000);
    do_reset();

    build(4'd6, 1'b0, 0, 5);
    run_q(4);
    chk("sw_mem_memWrite", 32'(memWrite), 32'd1);
    do_reset();

    build(4'd4, 1'b0, 1, 0);
    run_q(1000);
    chk("final_retired", 32'(retired), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
